// File: rtl/cluster_pkg.sv
// Shared cluster definitions for the cluster finder and the frame transmitter.
package cluster_pkg;

  localparam int MXADRBITS = 11;
  localparam int MXCNTBITS = 3;
  localparam int CLUSTER_W = MXADRBITS + MXCNTBITS;
  localparam logic [MXADRBITS-1:0] INVALID_ADR = 11'h7FE;

  // One cluster word as sent on the link: {cnt, adr}
  typedef struct packed {
    logic [MXCNTBITS-1:0] cnt;
    logic [MXADRBITS-1:0] adr;
  } cluster_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

  // Invalid clusters are replaced by a recognisable marker address with zero size
  function automatic cluster_t encode_cluster(input logic                 vpf,
                                              input logic [MXADRBITS-1:0] adr,
                                              input logic [MXCNTBITS-1:0] cnt);
    cluster_t c;
    if (vpf) begin
      c.cnt = cnt;
      c.adr = adr;
    end else begin
      c.cnt = '0;
      c.adr = INVALID_ADR;
    end
    return c;
  endfunction

endpackage

// File: rtl/frame_fifo.sv
// Frame FIFO: one entry per whole frame, pointers carry an extra wrap bit
// so full and empty are distinguishable. Read and write together are legal
// even when full, since the read frees the slot the write lands in.
module frame_fifo #(
  parameter int WIDTH = 112,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Frame storage; contents need no reset because the pointers gate visibility
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Pointer advance, modulo DEPTH with the extra wrap bit
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/cluster_frame_tx.sv
// Cluster frame transmitter: captures 8 clusters per latch_in pulse into a
// frame FIFO and serialises each frame as 4 beats of 2 clusters over
// valid/ready. Whole frames are dropped when the FIFO is full.
// Optional macro DROP_COUNT_EN adds the saturating drop_cnt output.
module cluster_frame_tx
  import cluster_pkg::*;
#(
  parameter int MXCLST = 8,
  parameter int BEATS  = 4,
  parameter int DEPTH  = 2
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          latch_in,
  input  logic [MXCLST*MXADRBITS-1:0]   adr_in,
  input  logic [MXCLST*MXCNTBITS-1:0]   cnt_in,
  input  logic [MXCLST-1:0]             vpf_in,
  output logic [(MXCLST/BEATS)*CLUSTER_W-1:0] word_out,
  output logic                          sof_out,
  output logic                          valid_out,
  input  logic                          ready_in,
  output logic                          overflow
`ifdef DROP_COUNT_EN
  ,
  output logic [15:0]                   drop_cnt
`endif
);

  localparam int WORD_W  = (MXCLST / BEATS) * CLUSTER_W;
  localparam int FRAME_W = MXCLST * CLUSTER_W;
  localparam int BW      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int QW      = $clog2(DEPTH + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  tx_state_t        state;
  logic [BW-1:0]    beat;
  logic [QW-1:0]    queued;
  logic [FRAME_W-1:0] frame_enc;
  logic [FRAME_W-1:0] head_frame;
  logic             fifo_full;
  logic             fifo_empty;
  logic             accept;
  logic             pop;
  logic             wr_en;
  logic             drop;
  logic             more;

  // Encode every cluster of the incoming frame
  always_comb begin
    frame_enc = '0;
    for (int i = 0; i < MXCLST; i++) begin
      frame_enc[i*CLUSTER_W +: CLUSTER_W] =
        encode_cluster(vpf_in[i],
                       adr_in[i*MXADRBITS +: MXADRBITS],
                       cnt_in[i*MXCNTBITS +: MXCNTBITS]);
    end
  end

  // A full FIFO still accepts a frame when its head is popped in the same cycle
  assign accept = valid_out && ready_in;
  assign pop    = accept && (beat == LAST_BEAT);
  assign wr_en  = latch_in && (!fifo_full || pop);
  assign drop   = latch_in && fifo_full && !pop;
  assign more   = (queued > QW'(1)) || wr_en;

  frame_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_data (frame_enc),
    .rd_en   (pop),
    .rd_data (head_frame),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Frames held in the FIFO, used to decide whether SEND continues without a gap
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      queued <= '0;
    end else if (wr_en && !pop) begin
      queued <= queued + 1'b1;
    end else if (pop && !wr_en) begin
      queued <= queued - 1'b1;
    end
  end

  // Transmitter FSM with registered valid/sof and the beat counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      beat      <= '0;
      valid_out <= 1'b0;
      sof_out   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_en || !fifo_empty) begin
            state     <= SEND;
            beat      <= '0;
            valid_out <= 1'b1;
            sof_out   <= 1'b1;
          end
        end
        SEND: begin
          if (accept) begin
            if (beat == LAST_BEAT) begin
              beat <= '0;
              if (more) begin
                sof_out <= 1'b1;
              end else begin
                state     <= IDLE;
                valid_out <= 1'b0;
                sof_out   <= 1'b0;
              end
            end else begin
              beat    <= beat + 1'b1;
              sof_out <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Beat mux from the stable head frame; forced to zero whenever nothing is offered
  always_comb begin
    word_out = '0;
    if (valid_out) word_out = head_frame[int'(beat)*WORD_W +: WORD_W];
  end

  // Registered drop indication
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) overflow <= 1'b0;
    else          overflow <= drop;
  end

`ifdef DROP_COUNT_EN
  // Saturating count of dropped frames
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                          drop_cnt <= '0;
    else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_cluster_frame_tx.sv
// Directed bench for cluster_frame_tx.
module tb_cluster_frame_tx;

  logic        clock;
  logic        reset_n;
  logic        latch_in;
  logic [87:0] adr_in;
  logic [23:0] cnt_in;
  logic [7:0]  vpf_in;
  logic [27:0] word_out;
  logic        sof_out;
  logic        valid_out;
  logic        ready_in;
  logic        overflow;
`ifdef DROP_COUNT_EN
  logic [15:0] drop_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  cluster_frame_tx dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .latch_in  (latch_in),
    .adr_in    (adr_in),
    .cnt_in    (cnt_in),
    .vpf_in    (vpf_in),
    .word_out  (word_out),
    .sof_out   (sof_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .overflow  (overflow)
`ifdef DROP_COUNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Frame with tag t: adr_i = i*100 + t, cnt_i = (i+t) % 8
  task automatic load_frame(input int tag, input logic [7:0] vpf);
    for (int i = 0; i < 8; i++) begin
      adr_in[i*11 +: 11] = 11'(i*100 + tag);
      cnt_in[i*3 +: 3]   = 3'((i + tag) % 8);
    end
    vpf_in = vpf;
  endtask

  function automatic logic [27:0] exp_beat(input int tag, input logic [7:0] vpf, input int b);
    logic [13:0] w [2];
    for (int j = 0; j < 2; j++) begin
      int i;
      i = 2*b + j;
      if (vpf[i]) w[j] = {3'((i + tag) % 8), 11'(i*100 + tag)};
      else        w[j] = {3'b000, 11'h7FE};
    end
    return {w[1], w[0]};
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; latch_in = 1'b0; ready_in = 1'b0;
    load_frame(0, 8'h00);
    repeat (2) tick();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", valid_out); end
    checks++; if (sof_out !== 1'b0) begin errors++; $display("FAIL reset_sof got=%0b exp=0", sof_out); end
    checks++; if (word_out !== 28'h0) begin errors++; $display("FAIL reset_word got=%h exp=0", word_out); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
`ifdef DROP_COUNT_EN
    checks++; if (drop_cnt !== 16'h0) begin errors++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); end
`endif
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_frame();
    ready_in = 1'b1;
    load_frame(0, 8'hFF);
    while (cyc < 10) tick();
    latch_in = 1'b1;
    tick();
    latch_in = 1'b0;
    checks++; if (word_out !== 28'h2190000) begin errors++; $display("FAIL single_beat0_const got=%h exp=2190000", word_out); end
    for (int b = 0; b < 4; b++) begin
      checks++;
      if ({valid_out, sof_out, word_out} !== {1'b1, (b == 0), exp_beat(0, 8'hFF, b)}) begin
        errors++;
        $display("FAIL single_beat%0d got v=%0b s=%0b w=%h exp v=1 s=%0b w=%h", b, valid_out, sof_out, word_out, (b == 0), exp_beat(0, 8'hFF, b));
      end
      tick();
    end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL single_idle got=%0b exp=0", valid_out); end
  endtask

  task automatic test_invalid();
    ready_in = 1'b1;
    load_frame(3, 8'h05);
    latch_in = 1'b1;
    tick();
    latch_in = 1'b0;
    for (int b = 0; b < 4; b++) begin
      checks++;
      if ({valid_out, sof_out, word_out} !== {1'b1, (b == 0), exp_beat(3, 8'h05, b)}) begin
        errors++;
        $display("FAIL invalid_beat%0d got w=%h exp w=%h", b, word_out, exp_beat(3, 8'h05, b));
      end
      if (b == 1) begin
        checks++;
        if (word_out !== 28'h1FFA8CB) begin errors++; $display("FAIL invalid_beat1_const got=%h exp=1ffa8cb", word_out); end
      end
      if (b == 3) begin
        checks++;
        if (word_out !== {14'h07FE, 14'h07FE}) begin errors++; $display("FAIL invalid_beat3_const got=%h exp=%h", word_out, {14'h07FE, 14'h07FE}); end
      end
      tick();
    end
  endtask

  task automatic test_back_pressure();
    ready_in = 1'b1;
    load_frame(5, 8'hFF);
    latch_in = 1'b1;
    tick();
    latch_in = 1'b0;
    checks++; if ({valid_out, sof_out, word_out} !== {2'b11, exp_beat(5, 8'hFF, 0)}) begin errors++; $display("FAIL bp_beat0 got=%h exp=%h", word_out, exp_beat(5, 8'hFF, 0)); end
    tick();
    ready_in = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if ({valid_out, sof_out, word_out} !== {2'b10, exp_beat(5, 8'hFF, 1)}) begin
        errors++;
        $display("FAIL bp_stall%0d got v=%0b s=%0b w=%h exp v=1 s=0 w=%h", k, valid_out, sof_out, word_out, exp_beat(5, 8'hFF, 1));
      end
      tick();
    end
    ready_in = 1'b1;
    for (int b = 1; b < 4; b++) begin
      checks++;
      if ({valid_out, sof_out, word_out} !== {2'b10, exp_beat(5, 8'hFF, b)}) begin
        errors++;
        $display("FAIL bp_beat%0d got w=%h exp w=%h", b, word_out, exp_beat(5, 8'hFF, b));
      end
      tick();
    end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL bp_idle got=%0b exp=0", valid_out); end
  endtask

  task automatic test_overflow();
    int pulses;
    pulses = 0;
    ready_in = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      load_frame(k, 8'hFF);
      latch_in = 1'b1;
      tick();
      if (overflow === 1'b1) pulses++;
      checks++;
      if (overflow !== (k >= 3)) begin errors++; $display("FAIL ovf_frame%0d got=%0b exp=%0b", k, overflow, (k >= 3)); end
    end
    latch_in = 1'b0;
    tick();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%0b exp=0", overflow); end
    checks++; if (pulses !== 2) begin errors++; $display("FAIL ovf_pulses got=%0d exp=2", pulses); end
`ifdef DROP_COUNT_EN
    checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL ovf_drop_cnt got=%0d exp=2", drop_cnt); end
`endif
    ready_in = 1'b1;
    for (int f = 1; f <= 2; f++) begin
      for (int b = 0; b < 4; b++) begin
        checks++;
        if ({valid_out, sof_out, word_out} !== {1'b1, (b == 0), exp_beat(f, 8'hFF, b)}) begin
          errors++;
          $display("FAIL ovf_f%0d_beat%0d got v=%0b s=%0b w=%h exp w=%h", f, b, valid_out, sof_out, word_out, exp_beat(f, 8'hFF, b));
        end
        tick();
      end
    end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL ovf_idle got=%0b exp=0", valid_out); end
  endtask

  task automatic test_full_and_pop();
    ready_in = 1'b0;
    load_frame(6, 8'hFF);
    latch_in = 1'b1;
    tick();
    load_frame(7, 8'hFF);
    tick();
    latch_in = 1'b0;
    ready_in = 1'b1;
    for (int b = 0; b < 4; b++) begin
      checks++;
      if ({valid_out, sof_out, word_out} !== {1'b1, (b == 0), exp_beat(6, 8'hFF, b)}) begin
        errors++;
        $display("FAIL fp_a_beat%0d got w=%h exp w=%h", b, word_out, exp_beat(6, 8'hFF, b));
      end
      if (b == 3) begin
        load_frame(8, 8'hFF);
        latch_in = 1'b1;
      end
      tick();
    end
    latch_in = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fp_overflow got=%0b exp=0", overflow); end
    for (int f = 7; f <= 8; f++) begin
      for (int b = 0; b < 4; b++) begin
        checks++;
        if ({valid_out, sof_out, word_out} !== {1'b1, (b == 0), exp_beat(f, 8'hFF, b)}) begin
          errors++;
          $display("FAIL fp_tag%0d_beat%0d got v=%0b s=%0b w=%h exp w=%h", f, b, valid_out, sof_out, word_out, exp_beat(f, 8'hFF, b));
        end
        tick();
      end
    end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL fp_idle got=%0b exp=0", valid_out); end
  endtask

  task automatic test_reset_mid_frame();
    ready_in = 1'b1;
    load_frame(9, 8'hFF);
    latch_in = 1'b1;
    tick();
    latch_in = 1'b0;
    repeat (2) tick();
    checks++; if (word_out !== exp_beat(9, 8'hFF, 2)) begin errors++; $display("FAIL rst_pre_beat2 got=%h exp=%h", word_out, exp_beat(9, 8'hFF, 2)); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if ({valid_out, sof_out, word_out, overflow} !== 31'h0) begin errors++; $display("FAIL rst_async got v=%0b s=%0b w=%h o=%0b exp all 0", valid_out, sof_out, word_out, overflow); end
`ifdef DROP_COUNT_EN
    checks++; if (drop_cnt !== 16'h0) begin errors++; $display("FAIL rst_drop_cnt got=%0d exp=0", drop_cnt); end
`endif
    load_frame(4, 8'hFF);
    latch_in = 1'b1;
    repeat (2) tick();
    reset_n = 1'b1;
    latch_in = 1'b0;
    repeat (2) tick();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rst_latch_ignored got=%0b exp=0", valid_out); end
    load_frame(12, 8'hFF);
    latch_in = 1'b1;
    tick();
    latch_in = 1'b0;
    for (int b = 0; b < 4; b++) begin
      checks++;
      if ({valid_out, sof_out, word_out} !== {1'b1, (b == 0), exp_beat(12, 8'hFF, b)}) begin
        errors++;
        $display("FAIL rst_fresh_beat%0d got v=%0b s=%0b w=%h exp w=%h", b, valid_out, sof_out, word_out, exp_beat(12, 8'hFF, b));
      end
      tick();
    end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rst_fresh_idle got=%0b exp=0", valid_out); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_invalid();
    test_back_pressure();
    test_overflow();
    test_full_and_pop();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
